regfile_scoreboard: RTL

Controller for the single-write-port register file of the pipelined RV32I core: tracks which architectural registers have writes in flight, stalls issue on RAW/WAW hazards or when too many writes are outstanding, and round-robin arbitrates the one write port between the ALU writeback path (wb0) and the load/store writeback path (wb1). It sits between decode/issue and the register file, and drives the register file's write port from registered outputs.

---
 rtl/regfile_scoreboard.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//
// Purpose:
//   Write-port controller for the RV32I register file. Tracks which
//   architectural registers have a write in flight, holds back issue on
//   RAW/WAW hazards or when too many writes are outstanding, and shares the
//   single register-file write port between the ALU writeback path (wb0) and
//   the load/store writeback path (wb1) with round-robin arbitration. The
//   register-file write port is driven from registers.
//
// Optional feature:
//   REGFILE_SB_STATS_EN - when defined, adds saturating stall and writeback
//   conflict cycle counters on stall_cycles / conflict_cycles.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   issue_valid              decode presents an instruction
//   issue_rs1_en/issue_rs1   source operand 1 used / address
//   issue_rs2_en/issue_rs2   source operand 2 used / address
//   issue_rd_en/issue_rd     instruction writes rd / destination address
//   issue_ready              no hazard; issue fires on valid && ready
//   wbN_valid/addr/data      writeback request from source N (0 = ALU, 1 = LSU)
//   wbN_ready                grant; transfer on valid && ready
//   rf_we/rf_waddr/rf_wdata  registered register-file write port
//   pending                  scoreboard bit vector (bit 0 always 0)
//   err                      sticky: writeback to a non-pending nonzero register
//   stall_cycles             (REGFILE_SB_STATS_EN) cycles with issue stalled
//   conflict_cycles          (REGFILE_SB_STATS_EN) cycles with both wb valid

module regfile_scoreboard #(
    parameter int XLEN    = 32,
    parameter int MAX_OUT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic            issue_rs1_en,
    input  logic            issue_rs2_en,
    input  logic [4:0]      issue_rs1,
    input  logic [4:0]      issue_rs2,
    input  logic            issue_rd_en,
    input  logic [4:0]      issue_rd,
    output logic            issue_ready,
    input  logic            wb0_valid,
    input  logic            wb1_valid,
    input  logic [4:0]      wb0_addr,
    input  logic [4:0]      wb1_addr,
    input  logic [XLEN-1:0] wb0_data,
    input  logic [XLEN-1:0] wb1_data,
    output logic            wb0_ready,
    output logic            wb1_ready,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [31:0]     pending,
    output logic            err
`ifdef REGFILE_SB_STATS_EN
    ,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     conflict_cycles
`endif
);

    localparam logic [4:0] LP_MAX_OUT = 5'(MAX_OUT);

    logic [31:0]     r_pending;
    logic [4:0]      r_cnt;
    logic            r_last;
    logic            r_rfWe;
    logic [4:0]      r_rfWaddr;
    logic [XLEN-1:0] r_rfWdata;
    logic            r_err;

    logic            w_rs1Hazard;
    logic            w_rs2Hazard;
    logic            w_rdHazard;
    logic            w_rdFull;
    logic            w_issueReady;
    logic            w_issueSet;
    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_gnt;
    logic [4:0]      w_gntAddr;
    logic [XLEN-1:0] w_gntData;
    logic            w_gntPending;
    logic            w_gntClear;
    logic            w_gntErr;
    logic [31:0]     w_pendingNext;
    logic [4:0]      w_cntNext;

    // Issue hazard checks look only at registered scoreboard state, so a
    // writeback clearing a bit in this same cycle cannot unblock issue until
    // the following cycle, when the register file bypass can supply the value.
    always_comb begin
        w_rs1Hazard  = issue_rs1_en && r_pending[issue_rs1];
        w_rs2Hazard  = issue_rs2_en && r_pending[issue_rs2];
        w_rdHazard   = issue_rd_en && r_pending[issue_rd];
        w_rdFull     = issue_rd_en && (issue_rd != 5'd0) && (r_cnt == LP_MAX_OUT);
        w_issueReady = !rst && !w_rs1Hazard && !w_rs2Hazard && !w_rdHazard && !w_rdFull;
        w_issueSet   = issue_valid && w_issueReady && issue_rd_en && (issue_rd != 5'd0);
    end

    // Round-robin arbitration: a lone requester always wins; under contention
    // the source that did not win last time is granted. r_last is 0 for wb0
    // and 1 for wb1, and resets to 1 so wb0 wins the first contention.
    always_comb begin
        w_gnt0    = !rst && wb0_valid && (!wb1_valid || r_last);
        w_gnt1    = !rst && wb1_valid && (!wb0_valid || !r_last);
        w_gnt     = w_gnt0 || w_gnt1;
        w_gntAddr = w_gnt1 ? wb1_addr : wb0_addr;
        w_gntData = w_gnt1 ? wb1_data : wb0_data;
    end

    // Classify the granted writeback: x0 writes pass through silently, a
    // nonzero pending register is retired, a nonzero non-pending register is
    // still written but flagged as an error.
    always_comb begin
        w_gntPending = r_pending[w_gntAddr];
        w_gntClear   = w_gnt && (w_gntAddr != 5'd0) && w_gntPending;
        w_gntErr     = w_gnt && (w_gntAddr != 5'd0) && !w_gntPending;
    end

    // Next scoreboard state. The clear is applied before the set so that a
    // same-register clear/set pair leaves the bit pending; the counter nets
    // to unchanged when one write retires while another is issued.
    always_comb begin
        w_pendingNext = r_pending;
        if (w_gntClear) begin
            w_pendingNext[w_gntAddr] = 1'b0;
        end
        if (w_issueSet) begin
            w_pendingNext[issue_rd] = 1'b1;
        end
        w_pendingNext[0] = 1'b0;

        w_cntNext = r_cnt;
        case ({w_issueSet, w_gntClear})
            2'b10:   w_cntNext = r_cnt + 5'd1;
            2'b01:   w_cntNext = r_cnt - 5'd1;
            default: w_cntNext = r_cnt;
        endcase
    end

    // Scoreboard, arbitration history and the registered register-file write
    // port. Address and data hold their last value when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_cnt     <= '0;
            r_last    <= 1'b1;
            r_rfWe    <= 1'b0;
            r_rfWaddr <= '0;
            r_rfWdata <= '0;
            r_err     <= 1'b0;
        end else begin
            r_pending <= w_pendingNext;
            r_cnt     <= w_cntNext;
            r_rfWe    <= w_gnt;
            if (w_gnt) begin
                r_last    <= w_gnt1;
                r_rfWaddr <= w_gntAddr;
                r_rfWdata <= w_gntData;
            end
            if (w_gntErr) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef REGFILE_SB_STATS_EN
    logic [31:0] r_stallCycles;
    logic [31:0] r_conflictCycles;

    // Saturating event counters; they stop at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCycles    <= '0;
            r_conflictCycles <= '0;
        end else begin
            if (issue_valid && !w_issueReady && (r_stallCycles != 32'hFFFF_FFFF)) begin
                r_stallCycles <= r_stallCycles + 32'd1;
            end
            if (wb0_valid && wb1_valid && (r_conflictCycles != 32'hFFFF_FFFF)) begin
                r_conflictCycles <= r_conflictCycles + 32'd1;
            end
        end
    end

    assign stall_cycles    = r_stallCycles;
    assign conflict_cycles = r_conflictCycles;
`else
    // Statistics counters are not built in this configuration.
`endif

    assign issue_ready = w_issueReady;
    assign wb0_ready   = w_gnt0;
    assign wb1_ready   = w_gnt1;
    assign rf_we       = r_rfWe;
    assign rf_waddr    = r_rfWaddr;
    assign rf_wdata    = r_rfWdata;
    assign pending     = r_pending;
    assign err         = r_err;

endmodule
